unidad_flags: RTL and testbench

Flag register and interrupt-context unit for the 16-bit single-cycle CPU. It receives the ALU flag outputs on one side: `carry`, `overflow` and `zero` for normal context, and `carry_intr` and `zero_intr` for interrupt context. It holds them in two register banks and evaluates branch conditions for the control unit. It also drives `interrupcion` back to the ALU. A small FSM sequences interrupt entry and return, so that flags from the interrupted program survive the service routine.

---
 rtl/unidad_flags_pkg.sv | 26 ++
 rtl/unidad_flags_if.sv | 16 +
 rtl/unidad_flags_eval_cond.sv | 22 ++
 rtl/unidad_flags.sv | 61 ++++++
 tb/tb_unidad_flags.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/unidad_flags_pkg.sv
// unidad_flags_pkg: condition codes, FSM encoding and flag bank type for unidad_flags
package unidad_flags_pkg;
  localparam logic [2:0] COND_SIEMPRE = 3'd0;
  localparam logic [2:0] COND_Z       = 3'd1;
  localparam logic [2:0] COND_NZ      = 3'd2;
  localparam logic [2:0] COND_C       = 3'd3;
  localparam logic [2:0] COND_NC      = 3'd4;
  localparam logic [2:0] COND_V       = 3'd5;
  localparam logic [2:0] COND_NV      = 3'd6;
  localparam logic [2:0] COND_NUNCA   = 3'd7;
  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_ENTRADA  = 2'd1;
  localparam logic [1:0] ST_SERVICIO = 2'd2;
  localparam logic [1:0] ST_SALIDA   = 2'd3;
  typedef enum logic [1:0] {
    NORMAL   = ST_NORMAL,
    ENTRADA  = ST_ENTRADA,
    SERVICIO = ST_SERVICIO,
    SALIDA   = ST_SALIDA
  } estado_t;
  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } banco_t;
endpackage

// File: rtl/unidad_flags_if.sv
// unidad_flags_if: ALU flag inputs, control decode inputs and branch/interrupt outputs
interface unidad_flags_if #(parameter int N_COND = 3, parameter int W_CNT = 8);
  logic carry, overflow, zero, carry_intr, zero_intr;
  logic we_flags, intr_req, ei, di, reti;
  logic [N_COND-1:0] cond;
  logic salto, interrupcion, intr_ack, flag_c, flag_v, flag_z;
  logic [W_CNT-1:0] cnt_intr;
  modport master (
    output carry, overflow, zero, carry_intr, zero_intr, we_flags, intr_req, ei, di, reti, cond,
    input  salto, interrupcion, intr_ack, flag_c, flag_v, flag_z, cnt_intr
  );
  modport slave (
    input  carry, overflow, zero, carry_intr, zero_intr, we_flags, intr_req, ei, di, reti, cond,
    output salto, interrupcion, intr_ack, flag_c, flag_v, flag_z, cnt_intr
  );
endinterface

// File: rtl/unidad_flags_eval_cond.sv
// eval_cond: branch decision from condition code and the active flag bank
module eval_cond
  import unidad_flags_pkg::*;
#(parameter int N_COND = 3) (
  input  logic [N_COND-1:0] cond,
  input  banco_t            f,
  output logic              salto
);
  always_comb begin
    salto = 1'b0;
    case (cond)
      COND_SIEMPRE: salto = 1'b1;
      COND_Z:       salto = f.z;
      COND_NZ:      salto = !f.z;
      COND_C:       salto = f.c;
      COND_NC:      salto = !f.c;
      COND_V:       salto = f.v;
      COND_NV:      salto = !f.v;
      default:      salto = 1'b0;
    endcase
  end
endmodule

// File: rtl/unidad_flags.sv
// unidad_flags: dual flag banks, branch evaluation and interrupt entry/return sequencing
module unidad_flags
  import unidad_flags_pkg::*;
#(parameter int N_COND = 3, parameter int W_CNT = 8) (
  input logic clk,
  input logic reset,
  unidad_flags_if.slave bus
);
  estado_t est_q, est_d;
  banco_t nb_q, nb_d, ib_q, ib_d, act;
  logic en_q, en_d, pend_q, pend_d, ack_q, ack_d, intr_q, intr_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  always_comb begin
    est_d = est_q;
    case (est_q)
      NORMAL:   est_d = pend_q ? ENTRADA : NORMAL;
      ENTRADA:  est_d = SERVICIO;
      SERVICIO: est_d = bus.reti ? SALIDA : SERVICIO;
      default:  est_d = pend_q ? ENTRADA : NORMAL;
    endcase
    nb_d = (est_q == NORMAL && bus.we_flags) ? {bus.carry, bus.overflow, bus.zero} : nb_q;
    ib_d = (est_q == ENTRADA) ? '0 :
           (est_q == SERVICIO && bus.we_flags) ? {bus.carry_intr, bus.overflow, bus.zero_intr} : ib_q;
    pend_d = (est_q == ENTRADA) ? 1'b0 : pend_q | (bus.intr_req & en_q);
    // hardware masking on entry/exit overrides ei/di decoded in the same cycle
    en_d = (est_q == ENTRADA) ? 1'b0 :
           (est_q == SALIDA)  ? 1'b1 :
           bus.di ? 1'b0 : bus.ei ? 1'b1 : en_q;
    cnt_d  = cnt_q + W_CNT'(est_q == ENTRADA);
    ack_d  = est_d == ENTRADA;
    intr_d = est_d == SERVICIO;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      est_q  <= NORMAL;
      nb_q   <= '0;
      ib_q   <= '0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      est_q  <= est_d;
      nb_q   <= nb_d;
      ib_q   <= ib_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      intr_q <= intr_d;
    end
  assign act = intr_q ? ib_q : nb_q;
  eval_cond #(.N_COND(N_COND)) u_eval_cond (.cond(bus.cond), .f(act), .salto(bus.salto));
  assign bus.interrupcion = intr_q;
  assign bus.intr_ack     = ack_q;
  assign bus.flag_c       = act.c;
  assign bus.flag_v       = act.v;
  assign bus.flag_z       = act.z;
  assign bus.cnt_intr     = cnt_q;
endmodule

// File: tb/tb_unidad_flags.sv
// tb_unidad_flags: scoreboard bench for unidad_flags against a cycle-level behavioural model
module tb_unidad_flags;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  unidad_flags_if #(.N_COND(3), .W_CNT(8)) bus ();
  unidad_flags #(.N_COND(3), .W_CNT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic carry, overflow, zero, ci, zi, we, req, ei, di, reti;
    logic [2:0] cond;
  } stim_t;
  typedef struct packed {
    logic salto, intr, ack, c, v, z;
    logic [7:0] cnt;
  } exp_t;
  localparam int RUN = 0, ENTERING = 1, SERVING = 2, LEAVING = 3;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  exp_t e;
  stim_t s;
  // model: normal flags {c,v,z}, interrupt flags, enable, pending, phase, services done
  bit [2:0] m_nf, m_if;
  bit m_en, m_pend;
  int m_mode;
  int m_served;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, req);
    end
  endtask
  function automatic bit branch(input logic [2:0] cd, input bit [2:0] f);
    bit c = f[2], v = f[1], z = f[0];
    case (cd)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return v;
      3'd6: return !v;
      default: return 1'b0;
    endcase
  endfunction
  function automatic exp_t model_out(input logic [2:0] cd);
    exp_t r;
    bit [2:0] f = (m_mode == SERVING) ? m_if : m_nf;
    r.salto = branch(cd, f);
    r.intr = m_mode == SERVING;
    r.ack = m_mode == ENTERING;
    {r.c, r.v, r.z} = f;
    r.cnt = 8'(m_served % 256);
    return r;
  endfunction
  task automatic model_reset();
    m_nf = 0; m_if = 0; m_en = 0; m_pend = 0; m_mode = RUN; m_served = 0;
  endtask
  task automatic model_step(input stim_t x);
    bit old_pend = m_pend;
    if (m_mode == RUN && x.we) m_nf = {x.carry, x.overflow, x.zero};
    if (m_mode == SERVING && x.we) m_if = {x.ci, x.overflow, x.zi};
    if (m_mode == ENTERING) begin
      m_if = 0;
      m_served++;
    end
    m_pend = (m_mode == ENTERING) ? 1'b0 : (m_pend || (x.req && m_en));
    if (m_mode == ENTERING) m_en = 0;
    else if (m_mode == LEAVING) m_en = 1;
    else if (x.di) m_en = 0;
    else if (x.ei) m_en = 1;
    case (m_mode)
      RUN:      m_mode = old_pend ? ENTERING : RUN;
      ENTERING: m_mode = SERVING;
      SERVING:  m_mode = x.reti ? LEAVING : SERVING;
      default:  m_mode = old_pend ? ENTERING : RUN;
    endcase
  endtask
  task automatic drive(input stim_t x);
    bus.carry = x.carry; bus.overflow = x.overflow; bus.zero = x.zero;
    bus.carry_intr = x.ci; bus.zero_intr = x.zi; bus.we_flags = x.we;
    bus.intr_req = x.req; bus.ei = x.ei; bus.di = x.di; bus.reti = x.reti;
    bus.cond = x.cond;
  endtask
  task automatic cycle(input stim_t x);
    drive(x);
    sb.push_back(model_out(x.cond));
    model_step(x);
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic [2:0] cd);
    stim_t z = '0;
    z.cond = cd;
    for (int i = 0; i < n; i++) cycle(z);
  endtask
  task automatic do_reset();
    exp_t r;
    #3;
    drive('0);
    #1 reset = 1'b1;
    model_reset();
    r = model_out(3'd0);
    #1;
    chk("rst_interrupcion", bus.interrupcion, r.intr);
    chk("rst_intr_ack", bus.intr_ack, r.ack);
    chk("rst_flags", {bus.flag_c, bus.flag_v, bus.flag_z}, {r.c, r.v, r.z});
    chk("rst_cnt_intr", bus.cnt_intr, r.cnt);
    chk("rst_salto", bus.salto, r.salto);
    @(negedge clk);
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("salto", bus.salto, e.salto);
      chk("interrupcion", bus.interrupcion, e.intr);
      chk("intr_ack", bus.intr_ack, e.ack);
      chk("flags_cvz", {bus.flag_c, bus.flag_v, bus.flag_z}, {e.c, e.v, e.z});
      chk("cnt_intr", bus.cnt_intr, e.cnt);
    end
  end
  initial begin
    drive('0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // flag capture and branch tests
    s = '0; s.we = 1; s.zero = 1; s.cond = 3'd1; cycle(s);
    s = '0; s.cond = 3'd1; cycle(s);
    s.cond = 3'd4; cycle(s);
    s.cond = 3'd3; cycle(s);
    // context save across a service routine
    s = '0; s.we = 1; s.carry = 1; cycle(s);
    s = '0; s.ei = 1; cycle(s);
    s = '0; s.req = 1; cycle(s);
    idle(3, 3'd3);
    s = '0; s.we = 1; s.ci = 0; s.zi = 1; s.cond = 3'd1; cycle(s);
    idle(1, 3'd1);
    s = '0; s.reti = 1; cycle(s);
    idle(3, 3'd3);
    // disabled interrupts drop requests
    s = '0; s.di = 1; cycle(s);
    s = '0; s.req = 1; cycle(s);
    idle(10, 3'd0);
    // back-to-back: request together with reti
    s = '0; s.ei = 1; cycle(s);
    s = '0; s.req = 1; cycle(s);
    idle(2, 3'd0);
    s = '0; s.ei = 1; cycle(s);
    s = '0; s.reti = 1; s.req = 1; cycle(s);
    idle(4, 3'd0);
    s = '0; s.reti = 1; cycle(s);
    idle(2, 3'd0);
    // asynchronous reset while servicing
    s = '0; s.ei = 1; cycle(s);
    s = '0; s.req = 1; cycle(s);
    idle(3, 3'd2);
    do_reset();
    // ei and di together: di wins
    s = '0; s.ei = 1; s.di = 1; cycle(s);
    s = '0; s.req = 1; cycle(s);
    idle(4, 3'd0);
    // counter wrap after 256 services
    for (int i = 0; i < 256; i++) begin
      s = '0; s.ei = 1; cycle(s);
      s = '0; s.req = 1; cycle(s);
      idle(2, 3'd0);
      s = '0; s.reti = 1; cycle(s);
      idle(1, 3'd0);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s.carry = 1'($urandom); s.overflow = 1'($urandom); s.zero = 1'($urandom);
      s.ci = 1'($urandom); s.zi = 1'($urandom); s.we = 1'($urandom);
      s.req = ($urandom % 8) == 0; s.ei = ($urandom % 5) == 0; s.di = ($urandom % 11) == 0;
      s.reti = ($urandom % 6) == 0; s.cond = 3'($urandom);
      cycle(s);
    end
    drive('0);
    #5;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
